// File: rtl/otter_intr_pkg.sv
// Shared definitions for the OTTER interrupt controller.
// Contents: controller FSM state type, register word offsets inside the
// 16-byte IOBUS window, the CLAIM value reported for a spurious
// acknowledge, and a helper that maps a byte offset to its word slot.
package otter_intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

  localparam logic [3:0]  OFS_ENABLE  = 4'h0;
  localparam logic [3:0]  OFS_PENDING = 4'h4;
  localparam logic [3:0]  OFS_MODE    = 4'h8;
  localparam logic [3:0]  OFS_CLAIM   = 4'hC;

  // Last byte offset that still counts as a hit on the register window.
  localparam logic [31:0] WINDOW_LAST = 32'h0000_000C;

  localparam logic [31:0] SPURIOUS_ID = 32'hFFFF_FFFF;

  // Byte offsets inside a word select the same register.
  function automatic logic [3:0] word_ofs(input logic [3:0] ofs);
    return {ofs[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_intr_prio_enc.sv
// Fixed-priority encoder for the interrupt controller.
// Ports:
//   eff   in  NUM_SRC  enabled pending requests
//   valid out 1        at least one bit of eff is set
//   index out IDX_W    position of the lowest set bit of eff (0 when none)
module otter_intr_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] eff,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic found_s;

  // Scan upward; the first set bit seen locks the index.
  always_comb begin
    found_s = 1'b0;
    index   = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      index   = (eff[i] && !found_s) ? IDX_W'(i) : index;
      found_s = found_s | eff[i];
    end
  end

  assign valid = |eff;

endmodule

// File: rtl/otter_intr_ctrl.sv
// Multi-source interrupt controller between peripheral IRQ lines and the
// OTTER MCU INTR input, with ENABLE / PENDING / MODE / CLAIM registers on
// the IOBUS.
// Ports:
//   CLK, RST       clock; asynchronous active-high reset
//   IRQ_IN         raw asynchronous requests, bit i = source i
//   IOBUS_ADDR     MCU IO address
//   IOBUS_OUT      MCU write data
//   IOBUS_WR       MCU write strobe
//   IOBUS_RD_DATA  register read data (combinational from IOBUS_ADDR)
//   IOBUS_HIT      address falls inside [BASE_ADDR, BASE_ADDR+0xC]
//   INTR           registered request to the MCU, high while in REQ
//   INTR_ACK       MCU trap-taken pulse
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic [31:0]        IOBUS_ADDR,
  input  logic [31:0]        IOBUS_OUT,
  input  logic               IOBUS_WR,
  output logic [31:0]        IOBUS_RD_DATA,
  output logic               IOBUS_HIT,
  output logic               INTR,
  input  logic               INTR_ACK
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
  logic [NUM_SRC-1:0] prev_r;
  logic [NUM_SRC-1:0] pend_r;
  logic [NUM_SRC-1:0] enable_r;
  logic [NUM_SRC-1:0] mode_r;
  logic [31:0]        claim_r;
  intr_state_t        state_r;
  intr_state_t        state_s;
  logic               intr_r;

  logic [NUM_SRC-1:0] synced_s;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] pend_view_s;
  logic [NUM_SRC-1:0] eff_s;
  logic [NUM_SRC-1:0] claim_mask_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] pend_next_s;
  logic [NUM_SRC-1:0] mode_next_s;
  logic [NUM_SRC-1:0] enable_next_s;
  logic [NUM_SRC-1:0] wdata_s;
  logic [31:0]        ofs_s;
  logic [3:0]         word_s;
  logic               hit_s;
  logic               wr_enable_s;
  logic               wr_pend_s;
  logic               wr_mode_s;
  logic               eoi_s;
  logic               ack_s;
  logic               prio_valid_s;
  logic [IDX_W-1:0]   prio_idx_s;
  logic [31:0]        rd_s;
  logic               unused_s;

  // Only the low NUM_SRC data bits carry register content.
  assign unused_s = ^IOBUS_OUT;
  assign wdata_s  = IOBUS_OUT[NUM_SRC-1:0];

  // Address decode: the window is 16 bytes, sub-word offsets alias.
  assign ofs_s  = IOBUS_ADDR - BASE_ADDR;
  assign hit_s  = (IOBUS_ADDR >= BASE_ADDR) && (ofs_s <= WINDOW_LAST);
  assign word_s = word_ofs(ofs_s[3:0]);

  assign wr_enable_s = IOBUS_WR && hit_s && (word_s == OFS_ENABLE);
  assign wr_pend_s   = IOBUS_WR && hit_s && (word_s == OFS_PENDING);
  assign wr_mode_s   = IOBUS_WR && hit_s && (word_s == OFS_MODE);
  assign eoi_s       = IOBUS_WR && hit_s && (word_s == OFS_CLAIM) && (state_r == SERVICE);
  assign ack_s       = INTR_ACK && (state_r == REQ);

  // Input path: the last stage of the chain is the synced level; prev_r
  // holds it one cycle later so a 0->1 step marks a rising edge.
  assign synced_s = sync_r[SYNC_STAGES-1];
  assign rise_s   = synced_s & ~prev_r;

  // Edge-mode bits come from the latch, level-mode bits track the line.
  assign pend_view_s = (pend_r & mode_r) | (synced_s & ~mode_r);
  assign eff_s       = pend_view_s & enable_r;

  otter_intr_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio (
    .eff   (eff_s),
    .valid (prio_valid_s),
    .index (prio_idx_s)
  );

  // One-hot of the source being claimed by this acknowledge.
  always_comb begin
    claim_mask_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask_s[i] = prio_valid_s && (prio_idx_s == IDX_W'(i));
    end
  end

  assign enable_next_s = wr_enable_s ? wdata_s : enable_r;
  assign mode_next_s   = wr_mode_s ? wdata_s : mode_r;

  // A new edge beats any clear in the same cycle; masking with the next
  // MODE drops latched edges on bits that become level-sensitive.
  assign clr_s       = (wr_pend_s ? wdata_s : {NUM_SRC{1'b0}})
                     | (ack_s ? claim_mask_s : {NUM_SRC{1'b0}});
  assign pend_next_s = ((pend_r & ~clr_s) | rise_s) & mode_next_s;

  // Next-state logic for the request/service handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (|eff_s) state_s = REQ;
        else        state_s = IDLE;
      end
      REQ: begin
        if (INTR_ACK)    state_s = SERVICE;
        else if (!(|eff_s)) state_s = IDLE;
        else             state_s = REQ;
      end
      SERVICE: begin
        if (eoi_s) state_s = IDLE;
        else       state_s = SERVICE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Register read mux; unused upper bits read zero.
  always_comb begin
    rd_s = 32'h0000_0000;
    if (hit_s) begin
      case (word_s)
        OFS_ENABLE:  rd_s[NUM_SRC-1:0] = enable_r;
        OFS_PENDING: rd_s[NUM_SRC-1:0] = pend_view_s;
        OFS_MODE:    rd_s[NUM_SRC-1:0] = mode_r;
        OFS_CLAIM:   rd_s = claim_r;
        default:     rd_s = 32'h0000_0000;
      endcase
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // IRQ synchroniser chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {NUM_SRC{1'b0}};
    end else begin
      sync_r[0] <= IRQ_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Control/status registers, FSM state and the INTR output flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_r   <= {NUM_SRC{1'b0}};
      pend_r   <= {NUM_SRC{1'b0}};
      enable_r <= {NUM_SRC{1'b0}};
      mode_r   <= {NUM_SRC{1'b0}};
      claim_r  <= SPURIOUS_ID;
      state_r  <= IDLE;
      intr_r   <= 1'b0;
    end else begin
      prev_r   <= synced_s;
      pend_r   <= pend_next_s;
      enable_r <= enable_next_s;
      mode_r   <= mode_next_s;
      state_r  <= state_s;
      intr_r   <= (state_s == REQ);
      if (ack_s) begin
        claim_r <= prio_valid_s ? {{(32-IDX_W){1'b0}}, prio_idx_s} : SPURIOUS_ID;
      end
    end
  end

  assign INTR          = intr_r;
  assign IOBUS_RD_DATA = rd_s;
  assign IOBUS_HIT     = hit_s;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Self-checking bench for otter_intr_ctrl: register-access vector table,
// directed multi-cycle sequences, then randomized traffic against a
// behavioural model of the controller.
module tb_otter_intr_ctrl;

  localparam int          N    = 8;
  localparam int          SS   = 2;
  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] O_EN = 32'h0, O_PE = 32'h4, O_MO = 32'h8, O_CL = 32'hC;
  localparam int S_IDLE = 0, S_REQ = 1, S_SERV = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [N-1:0] IRQ_IN = '0;
  logic [31:0] IOBUS_ADDR = BASE;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_RD_DATA;
  logic        IOBUS_HIT;
  logic        INTR;
  logic        INTR_ACK = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model state
  logic [N-1:0] m_pend, m_en, m_mode;
  logic [31:0]  m_claim;
  int           m_state;
  logic         m_intr;
  logic [N-1:0] hist[$];   // hist[k] = IRQ_IN sampled k+1 edges ago

  otter_intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SS), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST(RST), .IRQ_IN(IRQ_IN), .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR), .IOBUS_RD_DATA(IOBUS_RD_DATA),
    .IOBUS_HIT(IOBUS_HIT), .INTR(INTR), .INTR_ACK(INTR_ACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) <= 32'd12);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [N-1:0] synced;
    logic [31:0]  r;
    int           w;
    synced = hist[SS-1];
    r = 32'h0;
    w = int'((a - BASE) >> 2);
    if (m_hit(a)) begin
      if (w == 0) r[N-1:0] = m_en;
      else if (w == 1) r[N-1:0] = (m_pend & m_mode) | (synced & ~m_mode);
      else if (w == 2) r[N-1:0] = m_mode;
      else r = m_claim;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0;
    m_claim = 32'hFFFF_FFFF; m_state = S_IDLE; m_intr = 1'b0;
    hist.delete();
    for (int k = 0; k <= SS; k++) hist.push_back('0);
  endtask

  // Advance one clock: evaluate the rules with the current inputs, wait for
  // the edge, commit the model, and leave time at edge+1.
  task automatic step();
    logic [N-1:0] synced, rise, view, eff, nmode, npend, irq;
    int first, nst, w;
    logic hit, wr_en, wr_pe, wr_mo, eoi, ack;
    synced = hist[SS-1];
    rise   = synced & ~hist[SS];
    view   = (m_pend & m_mode) | (synced & ~m_mode);
    eff    = view & m_en;
    first  = -1;
    for (int i = N - 1; i >= 0; i--) if (eff[i]) first = i;
    hit   = m_hit(IOBUS_ADDR);
    w     = int'((IOBUS_ADDR - BASE) >> 2);
    wr_en = IOBUS_WR && hit && (w == 0);
    wr_pe = IOBUS_WR && hit && (w == 1);
    wr_mo = IOBUS_WR && hit && (w == 2);
    eoi   = IOBUS_WR && hit && (w == 3);
    ack   = INTR_ACK && (m_state == S_REQ);
    nst = m_state;
    if (m_state == S_IDLE && eff != 0) nst = S_REQ;
    else if (m_state == S_REQ && INTR_ACK) nst = S_SERV;
    else if (m_state == S_REQ && eff == 0) nst = S_IDLE;
    else if (m_state == S_SERV && eoi) nst = S_IDLE;
    nmode = wr_mo ? IOBUS_OUT[N-1:0] : m_mode;
    for (int i = 0; i < N; i++) begin
      if (!nmode[i]) npend[i] = 1'b0;
      else if (rise[i]) npend[i] = 1'b1;
      else if ((wr_pe && IOBUS_OUT[i]) || (ack && first == i)) npend[i] = 1'b0;
      else npend[i] = m_pend[i];
    end
    irq = IRQ_IN;
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      m_pend = npend;
      m_mode = nmode;
      if (wr_en) m_en = IOBUS_OUT[N-1:0];
      if (ack) m_claim = (first >= 0) ? 32'(first) : 32'hFFFF_FFFF;
      m_state = nst;
      m_intr  = (nst == S_REQ);
      hist.push_front(irq);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
    IOBUS_ADDR = BASE + ofs; IOBUS_OUT = data; IOBUS_WR = 1'b1;
    step();
    IOBUS_WR = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] ofs, input logic [31:0] exp);
    IOBUS_ADDR = BASE + ofs;
    #1;
    chk(name, IOBUS_RD_DATA, exp);
  endtask

  task automatic ack_pulse();
    INTR_ACK = 1'b1;
    step();
    INTR_ACK = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic        exp_intr;
  } vec_t;

  vec_t tbl[15];
  logic [31:0] rofs[7];
  logic [N-1:0] irq_v;

  initial begin
    tbl[0]  = '{BASE + 32'h0,  32'h0000_00A5, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{BASE + 32'h0,  32'h0,         1'b0, 32'h0000_00A5, 1'b1, 1'b0};
    tbl[2]  = '{BASE + 32'h8,  32'hFFFF_FF3C, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3]  = '{BASE + 32'h8,  32'h0,         1'b0, 32'h0000_003C, 1'b1, 1'b0};
    tbl[4]  = '{BASE + 32'hC,  32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[5]  = '{BASE + 32'h4,  32'h0,         1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6]  = '{BASE + 32'h10, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[7]  = '{BASE - 32'h4,  32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[8]  = '{BASE + 32'hC,  32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[9]  = '{BASE + 32'h10, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    tbl[10] = '{BASE + 32'h0,  32'h0,         1'b0, 32'h0000_00A5, 1'b1, 1'b0};
    tbl[11] = '{BASE + 32'h2,  32'h0,         1'b0, 32'h0000_00A5, 1'b1, 1'b0};
    tbl[12] = '{BASE + 32'h0,  32'h0,         1'b1, 32'h0000_00A5, 1'b1, 1'b0};
    tbl[13] = '{BASE + 32'h8,  32'h0,         1'b1, 32'h0000_003C, 1'b1, 1'b0};
    tbl[14] = '{BASE + 32'h0,  32'h0,         1'b0, 32'h0000_0000, 1'b1, 1'b0};

    // ---- power-on reset ----
    model_reset();
    steps(2);
    RST = 1'b0;
    chk("por_intr", {31'h0, INTR}, 32'h0);
    rd_chk("por_enable", O_EN, 32'h0);
    rd_chk("por_mode", O_MO, 32'h0);
    rd_chk("por_claim", O_CL, 32'hFFFF_FFFF);

    // ---- register access table ----
    for (int r = 0; r < 15; r++) begin
      IOBUS_ADDR = tbl[r].addr; IOBUS_OUT = tbl[r].wdata; IOBUS_WR = tbl[r].wr;
      #2;
      chk($sformatf("tbl%0d_rd", r), IOBUS_RD_DATA, tbl[r].exp_rd);
      chk($sformatf("tbl%0d_hit", r), {31'h0, IOBUS_HIT}, {31'h0, tbl[r].exp_hit});
      chk($sformatf("tbl%0d_intr", r), {31'h0, INTR}, {31'h0, tbl[r].exp_intr});
      step();
      IOBUS_WR = 1'b0;
    end

    // ---- reset while requesting (level mode, PENDING=0x05) ----
    wr(O_EN, 32'h05);
    IRQ_IN = 8'h05;
    steps(4);
    chk("rst_pre_intr", {31'h0, INTR}, 32'h1);
    rd_chk("rst_pre_pend", O_PE, 32'h05);
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_intr", {31'h0, INTR}, 32'h0);
    rd_chk("rst_enable", O_EN, 32'h0);
    rd_chk("rst_pend", O_PE, 32'h0);
    rd_chk("rst_mode", O_MO, 32'h0);
    rd_chk("rst_claim", O_CL, 32'hFFFF_FFFF);
    IRQ_IN = 8'h00;
    step();
    RST = 1'b0;
    step();

    // ---- single edge on source 3 ----
    wr(O_MO, 32'hFF);
    wr(O_EN, 32'h08);
    IRQ_IN = 8'h08;
    steps(3);
    chk("edge_lat_early", {31'h0, INTR}, 32'h0);
    IRQ_IN = 8'h00;
    step();
    chk("edge_lat", {31'h0, INTR}, 32'h1);
    rd_chk("edge_pend", O_PE, 32'h08);
    ack_pulse();
    chk("edge_ack_intr", {31'h0, INTR}, 32'h0);
    rd_chk("edge_claim", O_CL, 32'h3);
    rd_chk("edge_pend_clr", O_PE, 32'h0);
    wr(O_CL, 32'h0);
    steps(2);
    chk("edge_eoi_intr", {31'h0, INTR}, 32'h0);
    ack_pulse();
    rd_chk("edge_stray_ack", O_CL, 32'h3);

    // ---- priority and nesting: sources 5 and 2 together ----
    wr(O_EN, 32'hFF);
    IRQ_IN = 8'h24;
    steps(3);
    IRQ_IN = 8'h00;
    step();
    chk("prio_intr", {31'h0, INTR}, 32'h1);
    rd_chk("prio_pend", O_PE, 32'h24);
    ack_pulse();
    rd_chk("prio_claim1", O_CL, 32'h2);
    rd_chk("prio_pend1", O_PE, 32'h20);
    wr(O_CL, 32'h0);
    chk("prio_eoi_intr0", {31'h0, INTR}, 32'h0);
    step();
    chk("prio_reassert", {31'h0, INTR}, 32'h1);
    ack_pulse();
    rd_chk("prio_claim2", O_CL, 32'h5);
    rd_chk("prio_pend2", O_PE, 32'h0);
    wr(O_CL, 32'h0);
    step();
    chk("prio_idle", {31'h0, INTR}, 32'h0);

    // ---- level mode on source 0 ----
    wr(O_MO, 32'h00);
    wr(O_EN, 32'h01);
    IRQ_IN = 8'h01;
    steps(2);
    chk("lvl_lat_early", {31'h0, INTR}, 32'h0);
    step();
    chk("lvl_lat", {31'h0, INTR}, 32'h1);
    IRQ_IN = 8'h00;
    steps(2);
    chk("lvl_hold", {31'h0, INTR}, 32'h1);
    step();
    chk("lvl_withdraw", {31'h0, INTR}, 32'h0);
    IRQ_IN = 8'h01;
    steps(3);
    chk("lvl_again", {31'h0, INTR}, 32'h1);
    IRQ_IN = 8'h00;
    steps(2);
    ack_pulse();
    chk("spur_intr", {31'h0, INTR}, 32'h0);
    rd_chk("spur_claim", O_CL, 32'hFFFF_FFFF);
    wr(O_CL, 32'h0);
    step();

    // ---- masking and write-1-to-clear on source 1 ----
    wr(O_MO, 32'hFF);
    wr(O_EN, 32'h00);
    IRQ_IN = 8'h02;
    steps(3);
    IRQ_IN = 8'h00;
    step();
    rd_chk("mask_pend", O_PE, 32'h02);
    step();
    chk("mask_intr", {31'h0, INTR}, 32'h0);
    wr(O_EN, 32'h02);
    chk("unmask_early", {31'h0, INTR}, 32'h0);
    step();
    chk("unmask_intr", {31'h0, INTR}, 32'h1);
    wr(O_PE, 32'h02);
    rd_chk("w1c_pend", O_PE, 32'h0);
    step();
    chk("w1c_withdraw", {31'h0, INTR}, 32'h0);
    IRQ_IN = 8'h02;
    steps(2);
    wr(O_PE, 32'h02);
    rd_chk("set_wins", O_PE, 32'h02);
    IRQ_IN = 8'h00;
    step();
    chk("set_wins_intr", {31'h0, INTR}, 32'h1);
    ack_pulse();
    rd_chk("w1c_claim", O_CL, 32'h1);

    // ---- edge on source 4 arriving during SERVICE ----
    wr(O_EN, 32'h12);
    IRQ_IN = 8'h10;
    steps(3);
    IRQ_IN = 8'h00;
    steps(2);
    chk("svc_intr", {31'h0, INTR}, 32'h0);
    rd_chk("svc_pend", O_PE, 32'h10);
    wr(O_CL, 32'h0);
    chk("svc_eoi_intr0", {31'h0, INTR}, 32'h0);
    step();
    chk("svc_reassert", {31'h0, INTR}, 32'h1);
    ack_pulse();
    rd_chk("svc_claim", O_CL, 32'h4);
    wr(O_CL, 32'h0);
    step();

    // ---- randomized traffic against the model ----
    rofs[0] = 32'h0; rofs[1] = 32'h4; rofs[2] = 32'h8; rofs[3] = 32'hC;
    rofs[4] = 32'h2; rofs[5] = 32'h10; rofs[6] = 32'hFFFF_FFFC;
    irq_v = IRQ_IN;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) irq_v[i] = ~irq_v[i];
      IRQ_IN = irq_v;
      INTR_ACK = (m_state == S_REQ) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) begin
        IOBUS_WR   = 1'b1;
        IOBUS_ADDR = BASE + rofs[$urandom_range(0, 5)];
        IOBUS_OUT  = $urandom;
        if (IOBUS_ADDR == BASE + 32'h4 || IOBUS_ADDR == BASE + 32'h2) IOBUS_ADDR = BASE + 32'hC;
      end else begin
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = BASE + rofs[$urandom_range(0, 6)];
      end
      step();
      chk("rnd_intr", {31'h0, INTR}, {31'h0, m_intr});
      chk("rnd_hit", {31'h0, IOBUS_HIT}, {31'h0, m_hit(IOBUS_ADDR)});
      chk("rnd_rd", IOBUS_RD_DATA, m_rd(IOBUS_ADDR));
    end
    IOBUS_WR = 1'b0;
    INTR_ACK = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
